// File: rtl/scroll_pkg.sv
// Shared definitions for the message scroller: mode encoding and the step-period calculation.
package scroll_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  // 64-bit product: FREQ*DELAY_MS overflows 32 bits for ordinary clock rates.
  function automatic int calc_delay(input longint freq, input longint delay_ms);
    return int'((freq * delay_ms) / 1000);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running period divider: o_wrap is high for one cycle out of every DELAY enabled cycles.
module tick_divider #(
  parameter int DELAY = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [TW-1:0] LAST = TW'(DELAY - 1);

  logic [TW-1:0] tick_q, tick_d;

  assign o_wrap = i_en && (tick_q == LAST);

  always_comb begin
    tick_d = tick_q;
    if (i_clr || o_wrap) begin
      tick_d = '0;
    end else if (i_en) begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/scroll_window.sv
// Message scroll controller: writable nibble buffer viewed through a DISPLAYS-digit window.
// Optional bounce end-dwell is enabled by defining SCROLL_END_DWELL_EN.
module scroll_window
  import scroll_pkg::*;
#(
  parameter int                  DISPLAYS  = 4,
  parameter int                  DIGITS    = 18,
  parameter int                  FREQ      = 27_000_000,
  parameter int                  DELAY_MS  = 300,
  parameter int                  DELAY     = calc_delay(FREQ, DELAY_MS),
  parameter logic [4*DIGITS-1:0] INIT      = 72'hbea04ca55e123e4444,
  parameter int                  END_DWELL = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [1:0]                  i_mode,
  input  logic [$clog2(DIGITS):0]     i_len,
  input  logic                        i_pause,
  input  logic                        i_step,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [$clog2(DIGITS)-1:0]   i_wr_addr,
  input  logic [3:0]                  i_wr_data,
  output logic [4*DISPLAYS-1:0]       o_window,
  output logic [$clog2(DIGITS)-1:0]   o_offset,
  output logic                        o_step
);

  localparam int OW = $clog2(DIGITS);
  localparam int LW = $clog2(DIGITS) + 1;
  localparam logic [LW-1:0] DIGITS_L = LW'(DIGITS);
  localparam logic [LW-1:0] DISP_L   = LW'(DISPLAYS);

  logic [3:0]            buf_q [DIGITS];
  logic [OW-1:0]         offset_q, offset_d;
  logic                  fwd_q, fwd_d;
  mode_t                 mode_q;
  logic [LW-1:0]         len_q;
  logic [4*DISPLAYS-1:0] win_q, win_d;
  logic [OW-1:0]         out_off_q;
  logic                  step_q;

  mode_t         mode;
  logic [LW-1:0] len_eff, max_off, off_ext;
  logic          chg, wrap, step_apply, wr_ready, wr_en;

`ifdef SCROLL_END_DWELL_EN
  localparam int DWW = $clog2(END_DWELL + 2);
  logic [DWW-1:0] dwell_q, dwell_d;
`else
  // END_DWELL has no effect without the dwell feature.
  logic unused_dwell;
  assign unused_dwell = (END_DWELL != 0);
`endif

  assign mode    = mode_t'(i_mode);
  assign len_eff = (i_len == '0 || i_len > DIGITS_L) ? DIGITS_L : i_len;
  assign max_off = (len_eff > DISP_L) ? len_eff - DISP_L : '0;
  assign off_ext = {1'b0, offset_q};
  assign chg     = (mode != mode_q) || (len_eff != len_q);

  tick_divider #(.DELAY(DELAY)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    ((mode != MODE_STATIC) && !i_pause),
    .i_clr   (i_step || chg),
    .o_wrap  (wrap)
  );

  // A manual step and a divider wrap in the same cycle merge into one step.
  assign step_apply = (i_step || wrap) && !chg;
  assign wr_ready   = !i_reset && !step_apply;
  assign wr_en      = i_wr_valid && wr_ready && ({1'b0, i_wr_addr} < DIGITS_L);

  always_comb begin
    offset_d = offset_q;
    fwd_d    = fwd_q;
`ifdef SCROLL_END_DWELL_EN
    dwell_d  = dwell_q;
`endif
    if (chg) begin
      offset_d = '0;
      fwd_d    = 1'b1;
`ifdef SCROLL_END_DWELL_EN
      dwell_d  = '0;
`endif
    end else if (step_apply) begin
      case (mode)
        MODE_ROTL: offset_d = (off_ext + 1'b1 == len_eff) ? '0 : offset_q + 1'b1;
        MODE_ROTR: offset_d = (offset_q == '0) ? OW'(len_eff - 1'b1) : offset_q - 1'b1;
        MODE_BOUNCE: begin
          if (max_off == '0) begin
            offset_d = '0;
            fwd_d    = 1'b1;
`ifdef SCROLL_END_DWELL_EN
          end else if (dwell_q != '0 && !i_step) begin
            dwell_d = dwell_q - 1'b1;
`endif
          end else if (fwd_q) begin
            offset_d = offset_q + 1'b1;
            if (off_ext + 1'b1 >= max_off) fwd_d = 1'b0;
          end else begin
            offset_d = offset_q - 1'b1;
            if (off_ext <= LW'(1)) fwd_d = 1'b1;
          end
`ifdef SCROLL_END_DWELL_EN
          // Arriving at an end arms the dwell; any other move cancels it.
          if (offset_d != offset_q) dwell_d = (fwd_d != fwd_q) ? DWW'(END_DWELL) : '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Walk the window indices incrementally so wrap-around needs no divider.
  always_comb begin
    logic [OW-1:0] idx;
    idx   = offset_q;
    win_d = '0;
    for (int k = 0; k < DISPLAYS; k++) begin
      win_d[4*(DISPLAYS-k)-1 -: 4] = buf_q[idx];
      idx = ({1'b0, idx} + 1'b1 == len_q) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    mode_q <= mode;
    len_q  <= len_eff;
    if (i_reset) begin
      offset_q  <= '0;
      fwd_q     <= 1'b1;
      step_q    <= 1'b0;
      out_off_q <= '0;
      win_q     <= INIT[4*DIGITS-1 -: 4*DISPLAYS];
      for (int i = 0; i < DIGITS; i++) begin
        buf_q[i] <= INIT[4*(DIGITS-i)-1 -: 4];
      end
`ifdef SCROLL_END_DWELL_EN
      dwell_q   <= '0;
`endif
    end else begin
      offset_q  <= offset_d;
      fwd_q     <= fwd_d;
      step_q    <= step_apply;
      out_off_q <= offset_q;
      win_q     <= win_d;
      if (wr_en) buf_q[i_wr_addr] <= i_wr_data;
`ifdef SCROLL_END_DWELL_EN
      dwell_q   <= dwell_d;
`endif
    end
  end

  assign o_wr_ready = wr_ready;
  assign o_window   = win_q;
  assign o_offset   = out_off_q;
  assign o_step     = step_q;

endmodule

// File: tb/tb_scroll_window.sv
// Directed bench for scroll_window: DELAY=4, DISPLAYS=4, DIGITS=8, INIT=32'h01234567.
module tb_scroll_window;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  len;
  logic        pause, step, wr_valid;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ready, step_o;
  logic [15:0] window;
  logic [2:0]  offset;

  int total = 0;
  int bad   = 0;

  scroll_window #(
    .DISPLAYS  (4),
    .DIGITS    (8),
    .DELAY     (4),
    .INIT      (32'h01234567),
    .END_DWELL (2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_mode     (mode),
    .i_len      (len),
    .i_pause    (pause),
    .i_step     (step),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_window   (window),
    .o_offset   (offset),
    .o_step     (step_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] bounce_exp [6];

  initial begin
`ifdef SCROLL_END_DWELL_EN
    bounce_exp = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1};
`else
    bounce_exp = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd1};
`endif
    rst = 1'b1; mode = 2'd1; len = 4'd8; pause = 1'b0; step = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    cyc(2);
    check("reset_window", window, 16'h0123);
    check("reset_offset", offset, 3'd0);
    check("reset_step", step_o, 1'b0);
    check("reset_ready", wr_ready, 1'b0);
    rst = 1'b0;

    // rotate-left, one step every 4 cycles
    cyc(3);
    check("rotl_nostep_p3", step_o, 1'b0);
    check("rotl_ready_stepcycle", wr_ready, 1'b0);
    check("rotl_window_p3", window, 16'h0123);
    cyc(1);
    check("rotl_step_p4", step_o, 1'b1);
    check("rotl_ready_p4", wr_ready, 1'b1);
    cyc(1);
    check("rotl_window_1", window, 16'h1234);
    check("rotl_offset_1", offset, 3'd1);
    check("rotl_step_clear", step_o, 1'b0);
    cyc(4);
    check("rotl_window_2", window, 16'h2345);
    check("rotl_offset_2", offset, 3'd2);

    // rotate-right restarts from offset 0
    mode = 2'd2;
    cyc(1);
    check("rotr_chg_nostep", step_o, 1'b0);
    cyc(1);
    check("rotr_window_0", window, 16'h0123);
    check("rotr_offset_0", offset, 3'd0);
    cyc(3);
    check("rotr_step", step_o, 1'b1);
    cyc(1);
    check("rotr_window_7", window, 16'h7012);
    check("rotr_offset_7", offset, 3'd7);

    // bounce over six nibbles
    mode = 2'd3; len = 4'd6;
    cyc(2);
    check("bounce_off_0", offset, bounce_exp[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(4);
      check($sformatf("bounce_off_%0d", i), offset, bounce_exp[i]);
    end
    check("bounce_window_end", window, 16'h1234);

    // pause freezes, manual step advances once and restarts the divider
    mode = 2'd1; len = 4'd8;
    cyc(3);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("pause_window", window, 16'h0123);
      check("pause_step", step_o, 1'b0);
    end
    step = 1'b1;
    #1;
    check("manual_step_ready", wr_ready, 1'b0);
    cyc(1);
    step = 1'b0; pause = 1'b0;
    check("manual_step_pulse", step_o, 1'b1);
    cyc(1);
    check("manual_window", window, 16'h1234);
    check("manual_offset", offset, 3'd1);
    check("manual_single", step_o, 1'b0);
    cyc(2);
    check("tick_restart_nostep", step_o, 1'b0);
    cyc(1);
    check("tick_restart_step", step_o, 1'b1);

    // writes in static mode
    mode = 2'd0;
    cyc(1);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'hF;
    #1;
    check("write_ready", wr_ready, 1'b1);
    cyc(1);
    wr_valid = 1'b0;
    check("write_window_before", window, 16'h0123);
    cyc(1);
    check("write_window_after", window, 16'hF123);
    check("write_offset", offset, 3'd0);
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 4'hA; step = 1'b1;
    #1;
    check("write_blocked_by_step", wr_ready, 1'b0);
    cyc(1);
    step = 1'b0;
    #1;
    check("static_step_pulse", step_o, 1'b1);
    check("write_ready_after_step", wr_ready, 1'b1);
    cyc(1);
    wr_valid = 1'b0;
    check("static_window_held", window, 16'hF123);
    cyc(1);
    check("write2_window", window, 16'hFA23);
    check("write2_offset", offset, 3'd0);

    // short message repeats across the window
    mode = 2'd1; len = 4'd3;
    cyc(2);
    check("short_window_0", window, 16'hFA2F);
    check("short_offset_0", offset, 3'd0);
    cyc(3);
    check("short_step", step_o, 1'b1);
    cyc(1);
    check("short_window_1", window, 16'hA2FA);
    check("short_offset_1", offset, 3'd1);

    // length change on a step-due cycle suppresses that step
    cyc(2);
    len = 4'd5;
    cyc(1);
    check("lenchg_nostep", step_o, 1'b0);
    cyc(1);
    check("lenchg_offset", offset, 3'd0);
    check("lenchg_window", window, 16'hFA23);
    cyc(2);
    check("lenchg_tick_nostep", step_o, 1'b0);
    cyc(1);
    check("lenchg_tick_step", step_o, 1'b1);

    // 9 and 0 both clamp to 8: switching between them is not a change
    len = 4'd9;
    cyc(1);
    len = 4'd0;
    cyc(3);
    check("clamp_nostep", step_o, 1'b0);
    cyc(1);
    check("clamp_step", step_o, 1'b1);
    cyc(1);
    check("clamp_offset", offset, 3'd1);
    check("clamp_window", window, 16'hA234);

    // reset discards a pending write and step
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'hE; step = 1'b1;
    #1;
    check("midreset_ready", wr_ready, 1'b0);
    cyc(1);
    rst = 1'b0; wr_valid = 1'b0; step = 1'b0;
    check("midreset_window", window, 16'h0123);
    check("midreset_offset", offset, 3'd0);
    check("midreset_step", step_o, 1'b0);
    cyc(1);
    check("midreset_buffer", window, 16'h0123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
